dadda_product_serializer: RTL and testbench

Streams the 64-bit final product assembled at the end of the Dadda multiplier out as fixed-width chunks over a valid/ready interface, for narrow output ports and result FIFOs downstream of the multiplier. It accepts one full product word per handshake, holds it in an internal shift register, and emits `PROD_W/CHUNK_W` chunks with an index and a last-beat flag. It supports back-to-back products with no idle cycle between them.

---
 rtl/dadda_pkg.sv | 18 +
 rtl/dadda_product_serializer.sv | 87 ++++++++
 tb/tb_dadda_product_serializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiplier back end: default widths,
// serializer state encoding and the chunk-count helper.
package dadda_pkg;

  localparam int unsigned PROD_W_DEFAULT  = 64;
  localparam int unsigned CHUNK_W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int unsigned num_chunks(input int unsigned prod_w,
                                             input int unsigned chunk_w);
    return prod_w / chunk_w;
  endfunction

endpackage

// File: rtl/dadda_product_serializer.sv
// Streams one PROD_W-bit product word out as N = PROD_W/CHUNK_W chunks over
// valid/ready, with beat index and last flag; back-to-back products need no bubble.
module dadda_product_serializer
  import dadda_pkg::*;
#(
  parameter int unsigned PROD_W    = PROD_W_DEFAULT,
  parameter int unsigned CHUNK_W   = CHUNK_W_DEFAULT,
  parameter bit          MSB_FIRST = 1'b0,
  localparam int unsigned N        = num_chunks(PROD_W, CHUNK_W),
  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROD_W-1:0]  prod_in,
  input  logic               prod_valid,
  output logic               prod_ready,
  output logic [CHUNK_W-1:0] chunk_out,
  output logic               chunk_valid,
  input  logic               chunk_ready,
  output logic [IDX_W-1:0]   chunk_idx,
  output logic               chunk_last,
  output logic               busy
);

  if (PROD_W % CHUNK_W != 0) begin : g_bad_width
    $error("dadda_product_serializer: PROD_W must be a multiple of CHUNK_W");
  end

  ser_state_t        state;
  logic [PROD_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;
  logic              at_last;
  logic [PROD_W-1:0] sreg_shifted;

  assign at_last      = (idx == IDX_W'(N - 1));
  assign sreg_shifted = MSB_FIRST ? (sreg << CHUNK_W) : (sreg >> CHUNK_W);

  // Output view of the held word; everything here decodes registered state.
  assign chunk_valid = (state == SEND);
  assign busy        = (state == SEND);
  assign chunk_last  = (state == SEND) && at_last;
  assign chunk_idx   = idx;
  assign chunk_out   = MSB_FIRST ? sreg[PROD_W-1 -: CHUNK_W] : sreg[CHUNK_W-1:0];

  // Combinational path from chunk_ready: the next product may land on the
  // same edge that retires the last beat of the current one.
  assign prod_ready = (state == IDLE) || (chunk_last && chunk_ready);

  // State, shift register and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (prod_valid) begin
            sreg  <= prod_in;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (chunk_ready) begin
            if (!at_last) begin
              sreg <= sreg_shifted;
              idx  <= idx + IDX_W'(1);
            end else if (prod_valid) begin
              sreg <= prod_in;
              idx  <= '0;
            end else begin
              // Final shift empties the register so idle output reads zero.
              sreg  <= sreg_shifted;
              idx   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_product_serializer.sv
// Directed bench for dadda_product_serializer: LSB-first and MSB-first
// instances share stimulus and are checked against a chunk-queue model.
module tb_dadda_product_serializer;

  localparam int unsigned PW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned NC = PW / CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] prod_in;
  logic          prod_valid;
  logic          chunk_ready;

  logic          prod_ready0, prod_ready1;
  logic [CW-1:0] chunk_out0, chunk_out1;
  logic          chunk_valid0, chunk_valid1;
  logic [2:0]    chunk_idx0, chunk_idx1;
  logic          chunk_last0, chunk_last1;
  logic          busy0, busy1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  dadda_product_serializer #(.PROD_W(PW), .CHUNK_W(CW), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready0), .chunk_out(chunk_out0), .chunk_valid(chunk_valid0),
    .chunk_ready(chunk_ready), .chunk_idx(chunk_idx0), .chunk_last(chunk_last0),
    .busy(busy0)
  );

  dadda_product_serializer #(.PROD_W(PW), .CHUNK_W(CW), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready1), .chunk_out(chunk_out1), .chunk_valid(chunk_valid1),
    .chunk_ready(chunk_ready), .chunk_idx(chunk_idx1), .chunk_last(chunk_last1),
    .busy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each accepted product becomes N pending chunks in send order.
  logic [CW-1:0] q0[$];
  logic [CW-1:0] q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      bit accept;
      accept = (q0.size() == 0) || (q0.size() == 1 && chunk_ready);
      if (q0.size() > 0 && chunk_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (prod_valid && accept) begin
        for (int k = 0; k < NC; k++) begin
          q0.push_back(prod_in[k*CW +: CW]);
          q1.push_back(prod_in[(NC-1-k)*CW +: CW]);
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    bit pend;
    pend = (q0.size() > 0);
    chk("valid_lsb", 64'(chunk_valid0), 64'(pend));
    chk("valid_msb", 64'(chunk_valid1), 64'(pend));
    chk("busy_lsb", 64'(busy0), 64'(pend));
    chk("busy_msb", 64'(busy1), 64'(pend));
    chk("ready_lsb", 64'(prod_ready0), 64'(!pend || (q0.size() == 1 && chunk_ready)));
    chk("ready_msb", 64'(prod_ready1), 64'(!pend || (q1.size() == 1 && chunk_ready)));
    chk("last_lsb", 64'(chunk_last0), 64'(q0.size() == 1));
    chk("last_msb", 64'(chunk_last1), 64'(q1.size() == 1));
    if (pend) begin
      chk("data_lsb", 64'(chunk_out0), 64'(q0[0]));
      chk("data_msb", 64'(chunk_out1), 64'(q1[0]));
      chk("idx_lsb", 64'(chunk_idx0), 64'(NC - q0.size()));
      chk("idx_msb", 64'(chunk_idx1), 64'(NC - q1.size()));
    end
  end

  // Log of transferred beats for the literal checks.
  logic [CW-1:0] log0[$];
  logic [CW-1:0] log1[$];
  logic [2:0]    logi[$];
  int            logc[$];

  always @(posedge clk) begin
    if (rst_n && chunk_valid0 && chunk_ready) begin
      log0.push_back(chunk_out0);
      log1.push_back(chunk_out1);
      logi.push_back(chunk_idx0);
      logc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    log0.delete(); log1.delete(); logi.delete(); logc.delete();
  endtask

  task automatic send(input logic [PW-1:0] p, input bit hold, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    prod_in    = p;
    prod_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = prod_ready0;
      @(posedge clk);
      if (ok) acc = cyc;
      #1;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    if (!hold) prod_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = !busy0 && !busy1;
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  logic [CW-1:0] exp_lsb [NC];
  logic [CW-1:0] exp_msb [NC];
  logic [CW-1:0] exp_rst [NC];
  int acc_a, acc_b;

  initial begin
    exp_lsb = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    exp_msb = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    exp_rst = '{8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};

    // Reset values
    rst_n = 1'b0; prod_in = '0; prod_valid = 1'b0; chunk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prod_ready", 64'(prod_ready0), 64'd1);
    chk("rst_chunk_valid", 64'(chunk_valid0), 64'd0);
    chk("rst_chunk_last", 64'(chunk_last0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_chunk_out", 64'(chunk_out0), 64'd0);
    chk("rst_chunk_idx", 64'(chunk_idx0), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_prod_ready", 64'(prod_ready0), 64'd1);
    chk("post_rst_chunk_valid", 64'(chunk_valid0), 64'd0);

    // Single product, both orders, no backpressure
    chunk_ready = 1'b1;
    clear_logs();
    send(64'h0123_4567_89AB_CDEF, 1'b0, acc_a);
    wait_idle();
    chk("single_len", 64'(log0.size()), 64'(NC));
    for (int i = 0; i < NC && i < log0.size(); i++) begin
      chk("single_lsb_chunk", 64'(log0[i]), 64'(exp_lsb[i]));
      chk("single_msb_chunk", 64'(log1[i]), 64'(exp_msb[i]));
      chk("single_idx", 64'(logi[i]), 64'(i));
      chk("single_cycle", 64'(logc[i]), 64'(acc_a + 1 + i));
    end
    chk("single_busy_after", 64'(busy0), 64'd0);

    // Backpressure at beat 2
    clear_logs();
    send(64'h0123_4567_89AB_CDEF, 1'b0, acc_a);
    @(posedge clk); @(posedge clk); #1;
    chunk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_chunk", 64'(chunk_out0), 64'hAB);
      chk("bp_hold_idx", 64'(chunk_idx0), 64'd2);
    end
    @(posedge clk); #1;
    chunk_ready = 1'b1;
    wait_idle();
    chk("bp_len", 64'(log0.size()), 64'(NC));
    for (int i = 0; i < NC && i < log0.size(); i++)
      chk("bp_chunk", 64'(log0[i]), 64'(exp_lsb[i]));

    // Back-to-back products with prod_valid held
    clear_logs();
    send(64'h1111_1111_1111_1111, 1'b1, acc_a);
    send(64'h2222_2222_2222_2222, 1'b0, acc_b);
    wait_idle();
    chk("b2b_accept_gap", 64'(acc_b - acc_a), 64'(NC));
    chk("b2b_len", 64'(log0.size()), 64'(2 * NC));
    for (int i = 0; i < 2 * NC && i < log0.size(); i++) begin
      chk("b2b_chunk", 64'(log0[i]), (i < NC) ? 64'h11 : 64'h22);
      chk("b2b_cycle", 64'(logc[i]), 64'(logc[0] + i));
    end

    // Asynchronous reset mid-product
    clear_logs();
    send(64'h0123_4567_89AB_CDEF, 1'b0, acc_a);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_beats_sent", 64'(log0.size()), 64'd4);
    chk("mid_rst_valid", 64'(chunk_valid0), 64'd0);
    chk("mid_rst_busy", 64'(busy0), 64'd0);
    chk("mid_rst_prod_ready", 64'(prod_ready0), 64'd1);
    chk("mid_rst_chunk_out", 64'(chunk_out0), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    send(64'h0011_2233_4455_6677, 1'b0, acc_a);
    wait_idle();
    chk("after_rst_len", 64'(log0.size()), 64'(NC));
    for (int i = 0; i < NC && i < log0.size(); i++) begin
      chk("after_rst_chunk", 64'(log0[i]), 64'(exp_rst[i]));
      chk("after_rst_idx", 64'(logi[i]), 64'(i));
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
